// File: rtl/vanilla_commit_checker.sv
// rtl/vanilla_commit_checker.sv - in-order writeback commit checker against an expected-record stream
module vanilla_commit_checker #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 8,
  parameter int cnt_width_p      = 32,
  parameter bit halt_on_error_p  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        commit_v_i,
  input  logic [data_width_p-1:0]     commit_pc_i,
  input  logic                        commit_wen_i,
  input  logic                        commit_fp_i,
  input  logic [reg_addr_width_p-1:0] commit_waddr_i,
  input  logic [data_width_p-1:0]     commit_wdata_i,
  input  logic                        exp_v_i,
  output logic                        exp_ready_o,
  input  logic [data_width_p-1:0]     exp_pc_i,
  input  logic                        exp_wen_i,
  input  logic                        exp_fp_i,
  input  logic [reg_addr_width_p-1:0] exp_waddr_i,
  input  logic [data_width_p-1:0]     exp_wdata_i,
  output logic                        mismatch_o,
  output logic                        overflow_o,
  output logic [data_width_p-1:0]     first_err_pc_o,
  output logic [cnt_width_p-1:0]      commit_count_o,
  output logic [cnt_width_p-1:0]      mismatch_count_o,
  output logic [1:0]                  state_o
);

  localparam int ptr_w = $clog2(fifo_els_p);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERROR = 2'd2} state_e;
  state_e state;

  // Observed-commit FIFO, stored already normalized
  logic [data_width_p-1:0]     pc_mem    [fifo_els_p];
  logic                        wen_mem   [fifo_els_p];
  logic                        fp_mem    [fifo_els_p];
  logic [reg_addr_width_p-1:0] waddr_mem [fifo_els_p];
  logic [data_width_p-1:0]     wdata_mem [fifo_els_p];

  // Extra MSB distinguishes full from empty when the index bits match
  logic [ptr_w:0] wptr, rptr;
  logic empty, full;

  logic                        c_wen, c_fp, e_wen, e_fp;
  logic [reg_addr_width_p-1:0] c_waddr, e_waddr;
  logic [data_width_p-1:0]     c_wdata, e_wdata;

  logic [data_width_p-1:0]     h_pc, h_wdata;
  logic                        h_wen, h_fp;
  logic [reg_addr_width_p-1:0] h_waddr;

  logic match, mism, push_req, push, drop;

  // Normalize both sides: writes to int x0 are no-writes, no-writes carry no payload
  always_comb begin
    c_wen   = commit_wen_i & (commit_fp_i | (commit_waddr_i != '0));
    c_fp    = c_wen & commit_fp_i;
    c_waddr = c_wen ? commit_waddr_i : '0;
    c_wdata = c_wen ? commit_wdata_i : '0;
    e_wen   = exp_wen_i & (exp_fp_i | (exp_waddr_i != '0));
    e_fp    = e_wen & exp_fp_i;
    e_waddr = e_wen ? exp_waddr_i : '0;
    e_wdata = e_wen ? exp_wdata_i : '0;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[ptr_w] != rptr[ptr_w]) && (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]);

  assign h_pc    = pc_mem[rptr[ptr_w-1:0]];
  assign h_wen   = wen_mem[rptr[ptr_w-1:0]];
  assign h_fp    = fp_mem[rptr[ptr_w-1:0]];
  assign h_waddr = waddr_mem[rptr[ptr_w-1:0]];
  assign h_wdata = wdata_mem[rptr[ptr_w-1:0]];

  assign exp_ready_o = (state == RUN) && !empty && exp_v_i;
  assign state_o     = state;

  assign match = (h_pc == exp_pc_i) && (h_wen == e_wen) &&
                 (!h_wen || ((h_fp == e_fp) && (h_waddr == e_waddr) && (h_wdata == e_wdata)));
  assign mism  = exp_ready_o && !match;

  // A full FIFO still accepts a commit when the head pops in the same cycle
  assign push_req = (state == RUN) && enable_i && commit_v_i;
  assign push     = push_req && (!full || exp_ready_o);
  assign drop     = push_req && full && !exp_ready_o;

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wptr[ptr_w-1:0]]    <= commit_pc_i;
      wen_mem[wptr[ptr_w-1:0]]   <= c_wen;
      fp_mem[wptr[ptr_w-1:0]]    <= c_fp;
      waddr_mem[wptr[ptr_w-1:0]] <= c_waddr;
      wdata_mem[wptr[ptr_w-1:0]] <= c_wdata;
    end
  end

  // Control FSM, FIFO pointers, counters and sticky error reporting
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      wptr             <= '0;
      rptr             <= '0;
      mismatch_o       <= 1'b0;
      overflow_o       <= 1'b0;
      first_err_pc_o   <= '0;
      commit_count_o   <= '0;
      mismatch_count_o <= '0;
    end else begin
      if (exp_ready_o) begin
        rptr <= rptr + 1'b1;
        if (commit_count_o != '1) commit_count_o <= commit_count_o + 1'b1;
        if (mism) begin
          if (mismatch_count_o != '1) mismatch_count_o <= mismatch_count_o + 1'b1;
          mismatch_o <= 1'b1;
          if (!mismatch_o) first_err_pc_o <= h_pc;
        end
      end
      if (push) wptr <= wptr + 1'b1;
      if (drop) overflow_o <= 1'b1;
      case (state)
        IDLE: if (enable_i) state <= RUN;
        RUN: begin
          if (drop || (mism && halt_on_error_p)) begin
            state <= ERROR;
          end else if (!enable_i) begin
            state <= IDLE;
            wptr  <= '0;
            rptr  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vanilla_commit_checker.sv
// tb/tb_vanilla_commit_checker.sv - directed bench with queue-based reference model for two halt settings
module tb_vanilla_commit_checker;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic        fp;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  logic clk, reset_i, enable_i, commit_v_i, exp_v_i;
  rec_t cr, er;
  bit   rst_r, en_r;

  logic        exp_ready [2];
  logic        mis_o     [2];
  logic        ovf_o     [2];
  logic [31:0] fpc_o     [2];
  logic [31:0] cc_o      [2];
  logic [31:0] mc_o      [2];
  logic [1:0]  st_o      [2];

  int n_pass = 0;
  int n_total = 0;

  vanilla_commit_checker #(.halt_on_error_p(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .commit_v_i(commit_v_i), .commit_pc_i(cr.pc), .commit_wen_i(cr.wen), .commit_fp_i(cr.fp),
    .commit_waddr_i(cr.waddr), .commit_wdata_i(cr.wdata),
    .exp_v_i(exp_v_i), .exp_ready_o(exp_ready[0]),
    .exp_pc_i(er.pc), .exp_wen_i(er.wen), .exp_fp_i(er.fp), .exp_waddr_i(er.waddr), .exp_wdata_i(er.wdata),
    .mismatch_o(mis_o[0]), .overflow_o(ovf_o[0]), .first_err_pc_o(fpc_o[0]),
    .commit_count_o(cc_o[0]), .mismatch_count_o(mc_o[0]), .state_o(st_o[0])
  );

  vanilla_commit_checker #(.halt_on_error_p(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .commit_v_i(commit_v_i), .commit_pc_i(cr.pc), .commit_wen_i(cr.wen), .commit_fp_i(cr.fp),
    .commit_waddr_i(cr.waddr), .commit_wdata_i(cr.wdata),
    .exp_v_i(exp_v_i), .exp_ready_o(exp_ready[1]),
    .exp_pc_i(er.pc), .exp_wen_i(er.wen), .exp_fp_i(er.fp), .exp_waddr_i(er.waddr), .exp_wdata_i(er.wdata),
    .mismatch_o(mis_o[1]), .overflow_o(ovf_o[1]), .first_err_pc_o(fpc_o[1]),
    .commit_count_o(cc_o[1]), .mismatch_count_o(mc_o[1]), .state_o(st_o[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
  endtask

  function automatic rec_t rf(input logic [31:0] pc, input logic wen, input logic fp,
                              input logic [4:0] wa, input logic [31:0] wd);
    rec_t r;
    r.pc = pc; r.wen = wen; r.fp = fp; r.waddr = wa; r.wdata = wd;
    return r;
  endfunction

  function automatic rec_t r(input logic [31:0] pc, input logic wen, input logic [4:0] wa,
                             input logic [31:0] wd);
    return rf(pc, wen, 1'b0, wa, wd);
  endfunction

  // Architectural view: int x0 is never written, and a no-write has no payload
  function automatic rec_t norm(input rec_t x);
    rec_t y = x;
    if (y.wen && !y.fp && y.waddr == 5'd0) y.wen = 1'b0;
    if (!y.wen) begin y.fp = 1'b0; y.waddr = '0; y.wdata = '0; end
    return y;
  endfunction

  // Reference model: one instance per halt setting
  bit          halt  [2] = '{1'b1, 1'b0};
  int          m_st  [2];
  rec_t        mq    [2][$];
  logic [31:0] m_cc  [2];
  logic [31:0] m_mc  [2];
  logic [31:0] m_fpc [2];
  bit          m_mis [2];
  bit          m_ovf [2];
  bit          started = 0;

  function automatic bit m_rdy(input int k);
    return (m_st[k] == 1) && (mq[k].size() > 0) && exp_v_i;
  endfunction

  task automatic adv(input int k);
    bit   err;
    rec_t h;
    if (reset_i) begin
      m_st[k] = 0; mq[k].delete();
      m_cc[k] = 0; m_mc[k] = 0; m_fpc[k] = 0; m_mis[k] = 0; m_ovf[k] = 0;
      started = 1;
    end else if (m_st[k] == 0) begin
      if (enable_i) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      err = 0;
      if (m_rdy(k)) begin
        h = mq[k].pop_front();
        if (m_cc[k] != 32'hFFFF_FFFF) m_cc[k]++;
        if (h != norm(er)) begin
          if (m_mc[k] != 32'hFFFF_FFFF) m_mc[k]++;
          if (!m_mis[k]) m_fpc[k] = h.pc;
          m_mis[k] = 1;
          if (halt[k]) err = 1;
        end
      end
      if (enable_i && commit_v_i) begin
        if (mq[k].size() < 8) mq[k].push_back(norm(cr));
        else begin m_ovf[k] = 1; err = 1; end
      end
      if (err) m_st[k] = 2;
      else if (!enable_i) begin m_st[k] = 0; mq[k].delete(); end
    end
  endtask

  // Mid-cycle compare of every output against the model, then advance the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("state[%0d]", k), st_o[k], m_st[k]);
        chk($sformatf("exp_ready[%0d]", k), exp_ready[k], m_rdy(k));
        chk($sformatf("mismatch[%0d]", k), mis_o[k], m_mis[k]);
        chk($sformatf("overflow[%0d]", k), ovf_o[k], m_ovf[k]);
        chk($sformatf("first_err_pc[%0d]", k), fpc_o[k], m_fpc[k]);
        chk($sformatf("commit_count[%0d]", k), cc_o[k], m_cc[k]);
        chk($sformatf("mismatch_count[%0d]", k), mc_o[k], m_mc[k]);
      end
    end
    for (int k = 0; k < 2; k++) adv(k);
  end

  task automatic step(input bit cv, input rec_t c, input bit ev, input rec_t e);
    @(posedge clk); #1;
    reset_i = rst_r; enable_i = en_r;
    commit_v_i = cv; cr = c; exp_v_i = ev; er = e;
  endtask

  function automatic rec_t frec(input int i, input logic [31:0] base);
    if (i == 3) return rf(base + 4 * i, 1'b1, 1'b1, 5'd0, 32'hF000 + i);
    return r(base + 4 * i, 1'b1, 5'(i + 1), 32'(i));
  endfunction

  task automatic lit_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_state[%0d]", tag, k), st_o[k], 0);
      chk($sformatf("%s_cnt[%0d]", tag, k), cc_o[k], 0);
      chk($sformatf("%s_mcnt[%0d]", tag, k), mc_o[k], 0);
      chk($sformatf("%s_mis[%0d]", tag, k), mis_o[k], 0);
      chk($sformatf("%s_ovf[%0d]", tag, k), ovf_o[k], 0);
      chk($sformatf("%s_fpc[%0d]", tag, k), fpc_o[k], 0);
    end
  endtask

  rec_t z = '0;

  initial begin
    clk = 0; reset_i = 1; enable_i = 0; commit_v_i = 0; exp_v_i = 0; cr = '0; er = '0;
    rst_r = 1; en_r = 0;
    step(0, z, 0, z);
    step(0, z, 0, z);
    rst_r = 0; en_r = 1;
    step(0, z, 0, z);
    lit_zero("reset");

    // Four matching commits, expected stream one cycle behind, plus an x0 write
    step(1, r(32'h0, 1, 5'd1, 32'h11), 1, r(32'h0, 1, 5'd1, 32'h11));
    chk("enable_state", st_o[0], 1);
    step(1, r(32'h4, 1, 5'd2, 32'h22), 1, r(32'h0, 1, 5'd1, 32'h11));
    step(1, r(32'h8, 1, 5'd3, 32'h33), 1, r(32'h4, 1, 5'd2, 32'h22));
    step(1, r(32'hC, 1, 5'd4, 32'h44), 1, r(32'h8, 1, 5'd3, 32'h33));
    step(1, r(32'h10, 1, 5'd0, 32'h5), 1, r(32'hC, 1, 5'd4, 32'h44));
    step(0, z, 1, r(32'h10, 0, 5'd0, 32'h0));
    chk("four_cnt", cc_o[0], 4);
    chk("four_mis", mis_o[0], 0);
    chk("four_state", st_o[0], 1);
    step(0, z, 0, z);
    chk("x0_cnt", cc_o[0], 5);
    chk("x0_mis", mis_o[1], 0);

    // Data mismatch at 0x100
    step(1, r(32'h100, 1, 5'd5, 32'hDEAD), 0, z);
    step(0, z, 1, r(32'h100, 1, 5'd5, 32'hBEEF));
    step(1, r(32'h104, 0, 5'd0, 32'h0), 1, r(32'h104, 0, 5'd0, 32'h0));
    chk("halt_mis", mis_o[0], 1);
    chk("halt_mcnt", mc_o[0], 1);
    chk("halt_fpc", fpc_o[0], 32'h100);
    chk("halt_state", st_o[0], 2);
    chk("halt_ready", exp_ready[0], 0);
    chk("nohalt_state", st_o[1], 1);
    step(0, z, 1, r(32'h104, 0, 5'd0, 32'h0));
    chk("halt_ready2", exp_ready[0], 0);
    step(0, z, 0, z);
    chk("nohalt_cnt", cc_o[1], 7);
    chk("halt_cnt", cc_o[0], 6);

    // Two mismatches without halting
    rst_r = 1; step(0, z, 0, z);
    rst_r = 0; step(0, z, 0, z);
    lit_zero("rst2");
    step(1, r(32'h20, 1, 5'd6, 32'h1), 0, z);
    step(1, r(32'h30, 1, 5'd7, 32'h2), 1, r(32'h20, 1, 5'd6, 32'h9));
    step(1, r(32'h40, 1, 5'd8, 32'h3), 1, r(32'h30, 1, 5'd7, 32'h2));
    step(0, z, 1, r(32'h40, 1, 5'd8, 32'h4));
    step(0, z, 0, z);
    chk("two_mcnt", mc_o[1], 2);
    chk("two_fpc", fpc_o[1], 32'h20);
    chk("two_state", st_o[1], 1);
    chk("two_cnt", cc_o[1], 3);
    chk("two_halt_state", st_o[0], 2);

    // Overflow: nine commits with no expected records
    rst_r = 1; step(0, z, 0, z);
    rst_r = 0; step(0, z, 0, z);
    for (int i = 0; i < 9; i++) step(1, r(32'h200 + 4 * i, 1, 5'(i + 1), 32'(i)), 0, z);
    chk("full8_ovf", ovf_o[0], 0);
    chk("full8_state", st_o[1], 1);
    step(0, z, 1, r(32'h200, 1, 5'd1, 32'h0));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ovf[%0d]", k), ovf_o[k], 1);
      chk($sformatf("ovf_state[%0d]", k), st_o[k], 2);
      chk($sformatf("ovf_cnt[%0d]", k), cc_o[k], 0);
      chk($sformatf("ovf_ready[%0d]", k), exp_ready[k], 0);
    end

    // Full FIFO accepts a commit when the head pops the same cycle
    rst_r = 1; step(0, z, 0, z);
    rst_r = 0; step(0, z, 0, z);
    for (int i = 0; i < 8; i++) step(1, frec(i, 32'h300), 0, z);
    step(1, frec(8, 32'h300), 1, frec(0, 32'h300));
    for (int i = 1; i < 9; i++) step(0, z, 1, frec(i, 32'h300));
    step(0, z, 0, z);
    chk("fullpop_ovf", ovf_o[0], 0);
    chk("fullpop_cnt", cc_o[0], 9);
    chk("fullpop_mis", mis_o[0], 0);
    chk("fullpop_state", st_o[0], 1);

    // Disable with three queued entries flushes them; counters hold
    for (int i = 0; i < 3; i++) step(1, r(32'h400 + 4 * i, 1, 5'd1, 32'(i)), 0, z);
    en_r = 0; step(0, z, 0, z);
    en_r = 1; step(0, z, 0, z);
    chk("dis_state", st_o[1], 0);
    chk("dis_cnt", cc_o[1], 9);
    step(0, z, 1, r(32'h400, 1, 5'd1, 32'h0));
    chk("reen_state", st_o[1], 1);
    chk("reen_ready", exp_ready[1], 0);
    step(1, r(32'h600, 0, 5'd0, 32'h0), 1, r(32'h600, 0, 5'd0, 32'h0));
    chk("same_cycle_ready", exp_ready[1], 0);
    step(0, z, 1, r(32'h600, 0, 5'd0, 32'h0));
    step(0, z, 0, z);
    chk("reen_cnt", cc_o[1], 10);

    // Reset in the middle of a stream discards pending entries
    step(1, r(32'h500, 1, 5'd2, 32'h1), 0, z);
    step(1, r(32'h504, 1, 5'd2, 32'h2), 1, r(32'h500, 1, 5'd2, 32'h1));
    rst_r = 1;
    step(1, r(32'h508, 1, 5'd2, 32'h3), 1, r(32'h504, 1, 5'd2, 32'h2));
    rst_r = 0; en_r = 0;
    step(0, z, 0, z);
    lit_zero("midrst");
    chk("midrst_ready", exp_ready[0], 0);
    en_r = 1;
    step(0, z, 0, z);
    step(0, z, 1, r(32'h508, 1, 5'd2, 32'h3));
    chk("midrst_run", st_o[0], 1);
    chk("midrst_empty", exp_ready[0], 0);
    step(0, z, 0, z);
    step(0, z, 0, z);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vanilla_commit_checker.md
Name: vanilla_commit_checker

Overview:
Consumer end of the vanilla core's writeback commit stream. It captures each retired instruction's PC and register-file write at the WB stage, queues them, and compares them in order against a stream of expected commit records from a golden model or host.
It reports mismatches, counts, and the first failing PC. It sits beside the core in testbench and emulation builds and is synthesizable.

Parameters:
data_width_p, 32, width of RF write data and PC
reg_addr_width_p, 5, RF address width
fifo_els_p, 8, depth of observed-commit FIFO (power of 2, >=2)
cnt_width_p, 32, width of commit and mismatch counters
halt_on_error_p, 1, 1 = stop consuming expected records after the first mismatch

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
enable_i  in  1  checking enabled
commit_v_i  in  1  instruction retired at WB this cycle (no backpressure)
commit_pc_i  in  data_width_p  retired PC
commit_wen_i  in  1  retired instruction writes an RF
commit_fp_i  in  1  write targets float RF (else int RF)
commit_waddr_i  in  reg_addr_width_p  destination register
commit_wdata_i  in  data_width_p  write data (float data already un-recoded)
exp_v_i  in  1  expected record valid
exp_ready_o  out  1  expected record consumed this cycle
exp_pc_i, exp_wen_i, exp_fp_i, exp_waddr_i, exp_wdata_i  in  same widths as the commit_* ports  expected record fields
mismatch_o  out  1  sticky: any mismatch seen
overflow_o  out  1  sticky: a commit was dropped because the FIFO was full
first_err_pc_o  out  data_width_p  observed PC of the first mismatch
commit_count_o  out  cnt_width_p  records compared
mismatch_count_o  out  cnt_width_p  records that mismatched
state_o  out  2  0=IDLE 1=RUN 2=ERROR

Behaviour:
- Reset values: FIFO empty; state IDLE; exp_ready_o=0; all sticky flags, counters and first_err_pc_o = 0.
- States:
  - IDLE -> RUN when enable_i=1.
  - RUN -> IDLE when enable_i=0. The FIFO is flushed the same cycle and counters and flags are held.
  - RUN -> ERROR on a mismatch when halt_on_error_p=1, or on overflow regardless of the parameter.
  - ERROR is left only by reset_i.
- Enqueue: only in RUN, when commit_v_i=1.
  - Normalization: commit_wen_i=1 with commit_fp_i=0 and commit_waddr_i=0 is stored with wen=0, fp=0, waddr=0, wdata=0. When wen=0, fp/waddr/wdata are stored as 0.
  - The expected side is normalized identically before comparison.
- FIFO full and commit_v_i=1:
  - If a compare pops the same cycle, the push succeeds.
  - Otherwise the commit is dropped, overflow_o is set, and state goes to ERROR.
- exp_ready_o = (state==RUN) & FIFO non-empty & exp_v_i. It is combinational. A compare occurs exactly when exp_ready_o=1, and the FIFO head pops the same cycle.
- Latency: a commit enqueued at cycle t is comparable no earlier than cycle t+1.
- Match condition: pc equal, wen equal, and, if wen=1, fp, waddr and wdata all equal.
- On each compare: commit_count_o increments the next cycle, saturating at all-ones.
- On a mismatch:
  - mismatch_count_o increments, saturating.
  - mismatch_o is set the cycle after the compare.
  - first_err_pc_o captures the FIFO-head PC only if mismatch_o was 0.
- With halt_on_error_p=0, the block stays in RUN and keeps comparing after mismatches.
- In ERROR: no enqueue, exp_ready_o=0, FIFO contents frozen.
- Reset mid-operation: all state returns to reset values the next edge. Pending FIFO entries are discarded.
- With commit_v_i and a compare in the same cycle on an empty FIFO, no compare occurs that cycle. The new entry is compared at the earliest next cycle.

Test Plan:
- Reset, enable, 4 commits (PC 0x0,0x4,0x8,0xC, x1..x4=0x11..0x44) with matching expected records presented a cycle later -> commit_count_o=4, mismatch_o=0, state_o=1.
- Commit PC 0x100 writing x5=0xDEAD versus expected x5=0xBEEF, halt_on_error_p=1 -> mismatch_o=1, mismatch_count_o=1, first_err_pc_o=0x100, state_o=2, exp_ready_o stays 0 afterwards.
- halt_on_error_p=0: mismatches at PCs 0x20 then 0x40 -> mismatch_count_o=2, first_err_pc_o=0x20, state_o=1.
- Commit wen=1 to x0 with wdata=0x5 versus expected wen=0 at the same PC -> counted as a match.
- exp_v_i held 0 while 9 commits arrive with fifo_els_p=8 -> overflow_o=1 after the 9th commit, state_o=2, commit_count_o=0.
- Deassert enable_i with 3 entries queued, then re-enable -> FIFO empty, counters unchanged. Reset asserted mid-stream -> all outputs 0 and state_o=0.
